// File: rtl/dso_capture_ctrl.sv
// Acquisition controller: writes ADC samples into a circular RAM, enforces the pre-trigger fill, latches the trigger position.
// Write strobe/address/data appear 1 cycle after sample_valid; a low sample_valid stalls all counters.
module dso_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [ADDR_W-1:0] posttrig_len,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              edge_flag,
    input  logic              force_trig,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_ARMED = 2'd2,
        S_POST  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]   pre_len_q, pre_len_d;
    logic [ADDR_W-1:0]   post_len_q, post_len_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                write;
    logic [ADDR_W-1:0]   pre_cnt_inc;
    logic [ADDR_W-1:0]   post_target;

    assign pre_cnt_inc = pre_cnt_q + ADDR_W'(1);
    // A post length of 0 still records the trigger sample itself.
    assign post_target = (post_len_q == '0) ? ADDR_W'(1) : post_len_q;

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        done_d       = done_q;
        write        = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        pre_len_d  = pretrig_len;
                        post_len_d = posttrig_len;
                        done_d     = 1'b0;
                        wp_d       = '0;
                        pre_cnt_d  = '0;
                        post_cnt_d = '0;
                        state_d    = (pretrig_len == '0) ? S_ARMED : S_PRE;
                    end
                end
                S_PRE: begin
                    if (sample_valid) begin
                        write     = 1'b1;
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == pre_len_q) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (sample_valid) begin
                        write = 1'b1;
                        if (edge_flag || force_trig) begin
                            trig_addr_d  = wp_q;
                            start_addr_d = wp_q - pre_len_q;
                            post_cnt_d   = ADDR_W'(1);
                            state_d      = S_POST;
                        end
                    end
                end
                S_POST: begin
                    // Completion is taken one cycle after the final write was issued.
                    if (post_cnt_q == post_target) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (sample_valid) begin
                        write      = 1'b1;
                        post_cnt_d = post_cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end

        if (write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wp_q;
            wr_data_d = sample_in;
            wp_d      = wp_q + ADDR_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wp_q         <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed bench for dso_capture_ctrl: a 1024-deep instance for most scenarios, a 16-deep one for wrap-around.
module tb_dso_capture_ctrl;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          arm, abort, sample_valid, edge_flag, force_trig;
    logic [AW-1:0] pretrig_len, posttrig_len;
    logic [DW-1:0] sample_in;
    logic          wr_en, busy, done;
    logic [AW-1:0] wr_addr, trig_addr, start_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    state;

    logic          b_arm, b_sample_valid, b_edge_flag;
    logic [BW-1:0] b_pretrig_len, b_posttrig_len;
    logic [DW-1:0] b_sample_in;
    logic          b_wr_en, b_busy, b_done;
    logic [BW-1:0] b_wr_addr, b_trig_addr, b_start_addr;
    logic [DW-1:0] b_wr_data;
    logic [1:0]    b_state;

    dso_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .pretrig_len(pretrig_len), .posttrig_len(posttrig_len),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .edge_flag(edge_flag), .force_trig(force_trig),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .trig_addr(trig_addr), .start_addr(start_addr),
        .busy(busy), .done(done), .state(state)
    );

    dso_capture_ctrl #(.ADDR_W(BW), .DATA_W(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(b_arm), .abort(1'b0),
        .pretrig_len(b_pretrig_len), .posttrig_len(b_posttrig_len),
        .sample_in(b_sample_in), .sample_valid(b_sample_valid),
        .edge_flag(b_edge_flag), .force_trig(1'b0),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .trig_addr(b_trig_addr), .start_addr(b_start_addr),
        .busy(b_busy), .done(b_done), .state(b_state)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] wq[$];

    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_a(input int pre, input int post);
        pretrig_len  = AW'(pre);
        posttrig_len = AW'(post);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic smp(input logic v, input logic [DW-1:0] d, input logic e, input logic f);
        sample_valid = v;
        sample_in    = d;
        edge_flag    = e;
        force_trig   = f;
        cyc();
        sample_valid = 1'b0;
        edge_flag    = 1'b0;
        force_trig   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] vpat;
        logic [5:0] dpat;
        logic [AW+DW-1:0] exp_w;

        rst_n = 1'b1;
        arm = 0; abort = 0; sample_valid = 0; edge_flag = 0; force_trig = 0;
        pretrig_len = '0; posttrig_len = '0; sample_in = '0;
        b_arm = 0; b_sample_valid = 0; b_edge_flag = 0;
        b_pretrig_len = '0; b_posttrig_len = '0; b_sample_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_trig", trig_addr, 0);
        check("rst_start", start_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Basic record
        wq.delete();
        arm_a(4, 4);
        check("basic_pre", state, 1);
        check("basic_busy", busy, 1);
        for (int s = 0; s < 16; s++) begin
            smp(1'b1, DW'(s), s == 10, 1'b0);
            if (s == 2) check("basic_pre_hold", state, 1);
            if (s == 3) check("basic_armed", state, 2);
            if (s == 13) begin
                check("basic_last_wr_en", wr_en, 1);
                check("basic_last_wr_data", wr_data, 13);
                check("basic_done_early", done, 0);
            end
            if (s == 14) begin
                check("basic_done", done, 1);
                check("basic_busy_off", busy, 0);
                check("basic_no_wr", wr_en, 0);
            end
            if (s == 15) check("basic_no_wr2", wr_en, 0);
        end
        check("basic_nwr", wq.size(), 14);
        for (int i = 0; i < 14; i++) begin
            exp_w = {AW'(i), DW'(i)};
            check("basic_wr", wq[i], exp_w);
        end
        check("basic_trig", trig_addr, 10);
        check("basic_start", start_addr, 6);
        check("basic_addr_hold", wr_addr, 13);
        check("basic_idle", state, 0);

        // Early edges during the pre-trigger fill are ignored
        wq.delete();
        arm_a(4, 4);
        check("early_done_clr", done, 0);
        for (int s = 0; s < 12; s++) begin
            smp(1'b1, DW'(s), (s == 1) || (s == 2) || (s == 6), 1'b0);
            if (s == 2) check("early_still_pre", state, 1);
        end
        check("early_trig", trig_addr, 6);
        check("early_start", start_addr, 2);
        check("early_done", done, 1);
        check("early_nwr", wq.size(), 10);

        // Force trigger with zero pre and post lengths
        wq.delete();
        arm_a(0, 0);
        check("force_armed", state, 2);
        smp(1'b1, 8'hAA, 1'b0, 1'b1);
        check("force_wr_en", wr_en, 1);
        check("force_wr_addr", wr_addr, 0);
        check("force_trig", trig_addr, 0);
        check("force_start", start_addr, 0);
        check("force_post", state, 3);
        smp(1'b0, 8'h00, 1'b0, 1'b0);
        check("force_done", done, 1);
        check("force_idle", state, 0);
        check("force_no_wr", wr_en, 0);
        check("force_nwr", wq.size(), 1);

        // Stall during POST
        wq.delete();
        arm_a(0, 3);
        vpat = 6'b010101;
        dpat = 6'b100000;
        for (int c = 0; c < 6; c++) begin
            smp(vpat[c], DW'(50 + c), c == 0, 1'b0);
            check("stall_wr_en", wr_en, vpat[c]);
            check("stall_done", done, dpat[c]);
        end
        check("stall_nwr", wq.size(), 3);
        check("stall_w0", wq[0], {10'd0, 8'd50});
        check("stall_w1", wq[1], {10'd1, 8'd52});
        check("stall_w2", wq[2], {10'd2, 8'd54});

        // Abort and arm together while in POST
        arm_a(0, 8);
        smp(1'b1, 8'd1, 1'b0, 1'b1);
        smp(1'b1, 8'd2, 1'b0, 1'b0);
        check("abort_in_post", state, 3);
        abort = 1'b1;
        arm   = 1'b1;
        cyc();
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_en", wr_en, 0);
        wq.delete();
        arm_a(0, 1);
        smp(1'b1, 8'd77, 1'b1, 1'b0);
        smp(1'b0, 8'd0, 1'b0, 1'b0);
        check("rearm_done", done, 1);
        check("rearm_nwr", wq.size(), 1);
        check("rearm_w0", wq[0], {10'd0, 8'd77});

        // Asynchronous reset while ARMED
        arm_a(4, 4);
        for (int s = 0; s < 6; s++) smp(1'b1, DW'(s), 1'b0, 1'b0);
        check("rst_mid_armed", state, 2);
        sample_valid = 1'b1;
        sample_in    = 8'd9;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        check("rst_mid_state", state, 0);
        check("rst_mid_busy", busy, 0);
        sample_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp(1'b1, DW'(i), 1'b1, 1'b1);
            check("post_rst_no_wr", wr_en, 0);
            check("post_rst_idle", state, 0);
        end

        // Wrap-around on the 16-deep instance
        b_pretrig_len  = 4'd3;
        b_posttrig_len = 4'd2;
        b_arm = 1'b1;
        cyc();
        b_arm = 1'b0;
        for (int s = 0; s < 23; s++) begin
            b_sample_valid = 1'b1;
            b_sample_in    = DW'(s);
            b_edge_flag    = (s == 19);
            cyc();
            if (s == 15) check("wrap_addr15", b_wr_addr, 15);
            if (s == 16) begin
                check("wrap_addr0", b_wr_addr, 0);
                check("wrap_data16", b_wr_data, 16);
            end
        end
        b_sample_valid = 1'b0;
        b_edge_flag    = 1'b0;
        check("wrap_trig", b_trig_addr, 3);
        check("wrap_start", b_start_addr, 0);
        check("wrap_done", b_done, 1);
        check("wrap_addr_hold", b_wr_addr, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
